// File: rtl/element_diff_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : element_diff_acc_pkg
// Brief    : Shared types and defaults for the |difference| frame accumulator.
// Revision : 1.0
// ============================================================================
package element_diff_acc_pkg;

  localparam int D_W        = 16;
  localparam int SUM_W_DEF  = 20;
  localparam int N_ELEM_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/element_diff_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : element_diff_acc_if
// Brief    : Input stream, result handshake and status bundle for
//            element_diff_acc. The sat status exists only when
//            ELEMENT_DIFF_ACC_SAT_EN is defined.
// Revision : 1.0
// ============================================================================
interface element_diff_acc_if #(
  parameter int SUM_W = element_diff_acc_pkg::SUM_W_DEF
);
  import element_diff_acc_pkg::*;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [D_W-1:0]   d;
  logic [SUM_W-1:0] sum;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
`ifdef ELEMENT_DIFF_ACC_SAT_EN
  logic             sat;
`endif

  modport master (
    output start, in_valid, d, out_ready,
    input  in_ready, sum, out_valid,
`ifdef ELEMENT_DIFF_ACC_SAT_EN
    input  sat,
`endif
    input  busy
  );

  modport slave (
    input  start, in_valid, d, out_ready,
    output in_ready, sum, out_valid,
`ifdef ELEMENT_DIFF_ACC_SAT_EN
    output sat,
`endif
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/element_diff_acc_abs16.sv
`default_nettype none
// ============================================================================
// Module   : element_diff_acc_abs16
// Brief    : Combinational two's-complement magnitude, gate level:
//            conditional invert followed by a ripple increment.
// Revision : 1.0
// ============================================================================
module element_diff_acc_abs16
  import element_diff_acc_pkg::*;
(
  input  logic [D_W-1:0] i_d,
  output logic [D_W-1:0] o_abs
);

  logic           w_sign;
  logic [D_W-1:0] w_inv;
  logic [D_W-1:0] w_c;

  assign w_sign = i_d[D_W-1];
  assign w_c[0] = w_sign;

  // The result is unsigned, so -32768 maps cleanly onto 0x8000.
  for (genvar gi = 0; gi < D_W; gi++) begin : g_bit
    assign w_inv[gi] = i_d[gi] ^ w_sign;
    assign o_abs[gi] = w_inv[gi] ^ w_c[gi];
    if (gi < D_W - 1) begin : g_carry
      assign w_c[gi+1] = w_inv[gi] & w_c[gi];
    end
  end

endmodule
`default_nettype wire

// File: rtl/element_diff_acc.sv
`default_nettype none
// ============================================================================
// Module   : element_diff_acc
// Brief    : Sums |d| over N_ELEM elements per frame and hands the result
//            out over valid/ready. ELEMENT_DIFF_ACC_SAT_EN selects a
//            saturating accumulator with a sticky sat flag.
// Revision : 1.0
// ============================================================================
module element_diff_acc
  import element_diff_acc_pkg::*;
#(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  element_diff_acc_if.slave bus
);

  localparam int               CNT_W  = $clog2(N_ELEM + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_ELEM - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_sum;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_busy;
  logic             w_xfer;
  logic             w_last;
  logic             w_start_ok;
  logic             w_done_hs;
  logic [D_W-1:0]   w_abs;
  logic [SUM_W-1:0] w_abs_ext;
  logic [SUM_W-1:0] w_acc_nxt;

  element_diff_acc_abs16 u_abs (
    .i_d   (bus.d),
    .o_abs (w_abs)
  );

  assign w_abs_ext  = SUM_W'(w_abs);
  assign w_xfer     = bus.in_valid && (r_state == ACC);
  assign w_last     = (r_cnt == C_LAST);
  assign w_start_ok = bus.start && (r_state == IDLE);
  assign w_done_hs  = r_out_valid && bus.out_ready;

`ifdef ELEMENT_DIFF_ACC_SAT_EN
  logic [SUM_W:0] w_add;
  logic           w_ovf;
  logic           r_sat;

  // Carry out of the add marks overflow; clamping keeps a saturated acc pinned.
  assign w_add     = {1'b0, r_acc} + {1'b0, w_abs_ext};
  assign w_ovf     = w_add[SUM_W];
  assign w_acc_nxt = w_ovf ? {SUM_W{1'b1}} : w_add[SUM_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_start_ok) begin
      r_sat <= 1'b0;
    end else if (w_xfer && w_ovf) begin
      r_sat <= 1'b1;
    end
  end

  assign bus.sat = r_sat;
`else
  assign w_acc_nxt = r_acc + w_abs_ext;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = ACC;
        end
      end
      ACC: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (bus.in_valid && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_busy = 1'b1;
        if (r_out_valid && bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_cnt <= '0;
        r_acc <= '0;
      end
      if (w_xfer) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= w_acc_nxt;
        if (w_last) begin
          r_sum       <= w_acc_nxt;
          r_out_valid <= 1'b1;
        end
      end
      if (w_done_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;
  assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_element_diff_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_element_diff_acc
// Brief    : Self-checking bench: three instances (N=4/W=20, N=2/W=20,
//            N=3/W=16) driven with directed and random frames.
// Revision : 1.0
// ============================================================================
module tb_element_diff_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v     = '0;
  logic [2:0]  in_valid_v  = '0;
  logic [2:0]  out_ready_v = '0;
  logic [15:0] d_v [3];
  logic [15:0] q [$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  element_diff_acc_if #(.SUM_W(20)) if0 ();
  element_diff_acc_if #(.SUM_W(20)) if1 ();
  element_diff_acc_if #(.SUM_W(16)) if2 ();

  assign if0.start = start_v[0];  assign if0.in_valid = in_valid_v[0];
  assign if0.d     = d_v[0];      assign if0.out_ready = out_ready_v[0];
  assign if1.start = start_v[1];  assign if1.in_valid = in_valid_v[1];
  assign if1.d     = d_v[1];      assign if1.out_ready = out_ready_v[1];
  assign if2.start = start_v[2];  assign if2.in_valid = in_valid_v[2];
  assign if2.d     = d_v[2];      assign if2.out_ready = out_ready_v[2];

  element_diff_acc #(.N_ELEM(4), .SUM_W(20)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  element_diff_acc #(.N_ELEM(2), .SUM_W(20)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  element_diff_acc #(.N_ELEM(3), .SUM_W(16)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  wire [2:0]  in_ready_o  = {if2.in_ready,  if1.in_ready,  if0.in_ready};
  wire [2:0]  out_valid_o = {if2.out_valid, if1.out_valid, if0.out_valid};
  wire [2:0]  busy_o      = {if2.busy,      if1.busy,      if0.busy};
  wire [19:0] sum0        = if0.sum;
  wire [19:0] sum1        = if1.sum;
  wire [19:0] sum2        = {4'b0, if2.sum};
`ifdef ELEMENT_DIFF_ACC_SAT_EN
  wire [2:0]  sat_o       = {if2.sat, if1.sat, if0.sat};
`else
  wire [2:0]  sat_o       = 3'b000;
`endif

  function automatic logic [19:0] get_sum(input int k);
    case (k)
      0:       return sum0;
      1:       return sum1;
      default: return sum2;
    endcase
  endfunction

  function automatic int n_of(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int w_of(input int k);
    return (k == 2) ? 16 : 20;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer sum of magnitudes, then wrap or clamp.
  task automatic model(input int k, input logic [15:0] vals [$],
                       output longint s, output bit sat);
    longint tot = 0;
    longint mx  = (64'sd1 <<< w_of(k)) - 1;
    foreach (vals[i]) begin
      int v = int'($signed(vals[i]));
      tot += (v < 0) ? -v : v;
    end
`ifdef ELEMENT_DIFF_ACC_SAT_EN
    sat = (tot > mx);
    s   = sat ? mx : tot;
`else
    sat = 1'b0;
    s   = tot % (mx + 1);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input int k, input logic [15:0] vals [$],
                           input int hold, input int gap_max);
    longint exp_s;
    bit     exp_sat;
    model(k, vals, exp_s, exp_sat);
    out_ready_v[k] = (hold == 0);
    start_v[k]     = 1'b1;
    step();
    start_v[k]     = 1'b0;
    chk("busy_after_start", 32'(busy_o[k]), 32'd1);
    foreach (vals[i]) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid_v[k] = 1'b0;
        step();
      end
      in_valid_v[k] = 1'b1;
      d_v[k]        = vals[i];
      start_v[k]    = (i == 1);
      chk("in_ready_acc", 32'(in_ready_o[k]), 32'd1);
      chk("out_valid_acc", 32'(out_valid_o[k]), 32'd0);
      step();
    end
    in_valid_v[k] = 1'b0;
    start_v[k]    = 1'b0;
    chk("out_valid_lat", 32'(out_valid_o[k]), 32'd1);
    chk("sum", 32'(get_sum(k)), exp_s[31:0]);
    chk("sat", 32'(sat_o[k]), 32'(exp_sat));
    chk("in_ready_done", 32'(in_ready_o[k]), 32'd0);
    repeat (hold) begin
      in_valid_v[k] = 1'b1;
      d_v[k]        = 16'h7FFF;
      start_v[k]    = 1'b1;
      step();
      chk("sum_held", 32'(get_sum(k)), exp_s[31:0]);
      chk("out_valid_held", 32'(out_valid_o[k]), 32'd1);
      chk("in_ready_held", 32'(in_ready_o[k]), 32'd0);
    end
    in_valid_v[k]  = 1'b0;
    start_v[k]     = 1'b0;
    out_ready_v[k] = 1'b1;
    step();
    out_ready_v[k] = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid_o[k]), 32'd0);
    chk("busy_after_hs", 32'(busy_o[k]), 32'd0);
    chk("sum_kept", 32'(get_sum(k)), exp_s[31:0]);
  endtask

  task automatic rand_frame(input int k);
    q.delete();
    for (int i = 0; i < n_of(k); i++) begin
      case ($urandom_range(0, 3))
        0:       q.push_back(16'h8000);
        1:       q.push_back(16'($urandom_range(0, 15)));
        2:       q.push_back(16'hFFFF - 16'($urandom_range(0, 15)));
        default: q.push_back(16'($urandom));
      endcase
    end
    run_frame(k, q, $urandom_range(0, 3), 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) d_v[k] = 16'h1234;
    rst        = 1'b1;
    start_v    = 3'b111;
    in_valid_v = 3'b111;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 32'(in_ready_o[k]), 32'd0);
      chk("rst_out_valid", 32'(out_valid_o[k]), 32'd0);
      chk("rst_busy", 32'(busy_o[k]), 32'd0);
      chk("rst_sum", 32'(get_sum(k)), 32'd0);
      chk("rst_sat", 32'(sat_o[k]), 32'd0);
    end
    rst        = 1'b0;
    start_v    = '0;
    in_valid_v = '0;
    step();
    chk("idle_after_rst", 32'(busy_o), 32'd0);

    q = {16'd3, 16'hFFFB, 16'hFFFF, 16'd7};
    run_frame(0, q, 0, 0);
    run_frame(0, q, 5, 0);
    rand_frame(0);

    q = {16'h8000, 16'h8000};
    run_frame(1, q, 0, 0);

    q = {16'h8000, 16'h8000, 16'd5};
    run_frame(2, q, 1, 0);

    // Abort a frame after two elements, then check a clean restart.
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_v[0] = 1'b1;
      d_v[0]        = 16'd100;
      step();
    end
    in_valid_v[0] = 1'b0;
    rst           = 1'b1;
    step();
    rst           = 1'b0;
    chk("midrst_busy", 32'(busy_o[0]), 32'd0);
    chk("midrst_out_valid", 32'(out_valid_o[0]), 32'd0);
    chk("midrst_sum", 32'(get_sum(0)), 32'd0);
    chk("midrst_in_ready", 32'(in_ready_o[0]), 32'd0);
    q = {16'd1, 16'd2, 16'hFFFD, 16'd4};
    run_frame(0, q, 2, 1);

    for (int i = 0; i < 20; i++) rand_frame(0);
    for (int i = 0; i < 10; i++) rand_frame(1);
    for (int i = 0; i < 20; i++) rand_frame(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
